input_controller: RTL and testbench
===================================

Name: input_controller

Overview:
- Converts the asynchronous player jump key and the game frame-rate clock into interrupt instruction words for the processor, all in the processor clock domain.
- Once per frame-rate clock rising edge, emits one single-cycle interrupt instruction. The instruction reports whether a jump press occurred since the previous frame; otherwise the output is NOP.
- The frame-rate clock comes from an external clock_divider, which is not part of this block.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive proc_clk cycles the synchronized key must hold a new level before the level is accepted (must be ≥1).
INT_OPCODE, 5'b10101, opcode placed in bits [31:27] of the interrupt instruction.

Ports:
proc_clk  input  1  processor clock; the only clock; all registers on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
jump_key  input  1  raw jump key, active-high, asynchronous to proc_clk.
frame_rt_clk  input  1  frame-rate clock (nominal 60 Hz), treated as asynchronous data, never used as a clock.
interrupt_instrucion  output  32  interrupt instruction word; 32'h0 = NOP. Port name spelled exactly so.

Behaviour:
- Reset (reset=0, asynchronous assert; deassert takes effect at next proc_clk edge):
  - all synchronizer, debounce, edge-detect and pending registers are cleared;
  - interrupt_instrucion = 32'h0.
- Key path:
  - jump_key passes through a 2-FF synchronizer, then a debouncer.
  - The debounce counter counts cycles where the synchronized level ≠ the accepted level. It resets to 0 when the two are equal. When it reaches DEBOUNCE_CYCLES, the accepted level takes the new value and the counter clears.
  - A 0→1 transition of the accepted level is a "press". Holding the key produces exactly one press; release produces nothing.
  - A press sets the sticky jump_pending flag.
- Frame path:
  - frame_rt_clk passes through a 2-FF synchronizer plus a previous-value register.
  - frame_tick = sync & ~prev (one proc_clk cycle wide).
  - A rising edge of frame_rt_clk before proc_clk edge k gives frame_tick high between edges k+1 and k+2.
- Output register:
  - On a cycle with frame_tick=1, the next edge loads {INT_OPCODE, 25'b0, J, 1'b1}. J = jump_pending OR (press this cycle).
  - On every other cycle the output loads 32'h0. Each instruction is therefore high for exactly one proc_clk cycle.
  - Latency from frame edge to instruction is 3 proc_clk rising edges.
- jump_pending clears on the same edge that loads the instruction. A press coinciding with frame_tick is reported in that instruction and does not remain pending.
- Multiple presses within one frame collapse into one J=1.
- A press with no frame tick stays pending indefinitely.
- If frame_rt_clk is already high when reset deasserts, one tick and instruction follow 3 edges later. This is accepted behaviour.
- No input is ever used as a clock or as a reset.

Decomposition:
- Shared package holds:
  - INT_OPCODE default;
  - bit indices: OPCODE_MSB=31, OPCODE_LSB=27, JUMP_BIT=1, FRAME_BIT=0;
  - the NOP constant 32'h0.
- One natural sub-module: sync_debounce. It contains the 2-FF synchronizer plus the debouncer, is parameterized by DEBOUNCE_CYCLES, and outputs the accepted level and a press pulse.
- The frame edge detector stays inline in input_controller.

Test Plan:
- Reset and frame edge:
  - reset=0 with inputs toggling → output 32'h0 throughout.
  - Release reset, frame_rt_clk low; drive one frame_rt_clk rising edge → after 3 edges output = 32'hA8000001 for exactly 1 cycle, then 32'h0.
- Press then frame: DEBOUNCE_CYCLES=4, hold jump_key=1 for 10 cycles, release, then one frame edge → 32'hA8000003 once. The next frame edge gives 32'hA8000001 (pending cleared, hold did not repeat).
- Glitch rejection: jump_key high for only 3 cycles (DEBOUNCE_CYCLES=4), then a frame edge → 32'hA8000001.
- Two presses in one frame: two separate debounced presses before a frame edge → a single 32'hA8000003; the subsequent frame gives 32'hA8000001.
- Coincident press and tick: debounced press lands on the same cycle as frame_tick → 32'hA8000003, and the following frame gives 32'hA8000001. Then assert reset mid-frame with a press pending → output 0 immediately. After release, the next frame gives 32'hA8000001.

Source files
------------

// File: rtl/input_controller_pkg.sv
// Shared constants for the input controller: interrupt word layout,
// default opcode and the NOP word, plus a helper that builds the word.
package input_controller_pkg;

    localparam logic [4:0]  INT_OPCODE_DEF = 5'b10101;

    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 27;
    localparam int          JUMP_BIT   = 1;
    localparam int          FRAME_BIT  = 0;

    localparam logic [31:0] NOP = 32'h0;

    function automatic logic [31:0] make_instr(
        input logic [4:0] op,
        input logic       jump
    );
        logic [31:0] w;
        w                        = NOP;
        w[OPCODE_MSB:OPCODE_LSB] = op;
        w[JUMP_BIT]              = jump;
        w[FRAME_BIT]             = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/input_controller_sync_debounce.sv
// 2-FF synchronizer plus debouncer for a raw asynchronous key.
// Ports: i_clk, i_rst_n (async active-low), i_key (raw key),
//        o_level (accepted level), o_press (1-cycle pulse on accepted 0->1).
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // The counter holds the number of mismatching cycles already seen;
    // the DEBOUNCE_CYCLES-th mismatch flips the accepted level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/input_controller.sv
// Turns the jump key and frame-rate clock into one-cycle interrupt words.
// Ports: proc_clk, reset (async active-low), jump_key, frame_rt_clk (data),
//        interrupt_instrucion (32-bit word, 0 = NOP).
module input_controller
    import input_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [4:0]  INT_OPCODE      = INT_OPCODE_DEF
) (
    input  logic        proc_clk,
    input  logic        reset,
    input  logic        jump_key,
    input  logic        frame_rt_clk,
    output logic [31:0] interrupt_instrucion
);

    logic        w_level;
    logic        w_press;
    logic        w_frame_tick;
    logic        w_jump;

    logic        r_frame_sync1;
    logic        r_frame_sync2;
    logic        r_frame_prev;
    logic        r_jump_pending;
    logic [31:0] r_instr;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .i_clk  (proc_clk),
        .i_rst_n(reset),
        .i_key  (jump_key),
        .o_level(w_level),
        .o_press(w_press)
    );

    always_ff @(posedge proc_clk or negedge reset) begin
        if (!reset) begin
            r_frame_sync1 <= 1'b0;
            r_frame_sync2 <= 1'b0;
            r_frame_prev  <= 1'b0;
        end else begin
            r_frame_sync1 <= frame_rt_clk;
            r_frame_sync2 <= r_frame_sync1;
            r_frame_prev  <= r_frame_sync2;
        end
    end

    assign w_frame_tick = r_frame_sync2 & ~r_frame_prev;

    // A press landing on the tick cycle is reported now, not carried over.
    assign w_jump = r_jump_pending | w_press;

    always_ff @(posedge proc_clk or negedge reset) begin
        if (!reset) begin
            r_jump_pending <= 1'b0;
            r_instr        <= NOP;
        end else if (w_frame_tick) begin
            r_jump_pending <= 1'b0;
            r_instr        <= make_instr(INT_OPCODE, w_jump);
        end else begin
            r_jump_pending <= w_jump;
            r_instr        <= NOP;
        end
    end

    assign interrupt_instrucion = r_instr;

    logic w_unused;
    assign w_unused = w_level;

endmodule

// File: tb/tb_input_controller.sv
// Scoreboard bench for input_controller: stimulus pushes expected words
// with their expected cycle; a monitor pops on every non-NOP output.
module tb_input_controller;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        key;
    logic        frame;
    logic [31:0] instr;

    int   checks;
    int   errors;
    int   cyc;
    exp_t sb[$];

    input_controller #(
        .DEBOUNCE_CYCLES(4),
        .INT_OPCODE     (5'b10101)
    ) dut (
        .proc_clk            (clk),
        .reset               (rst_n),
        .jump_key            (key),
        .frame_rt_clk        (frame),
        .interrupt_instrucion(instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every non-NOP word must match the oldest expectation,
    // both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (rst_n && instr != 32'h0) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_instr got %h at cycle %0d, none expected",
                         instr, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr !== e.word || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL instr got %h at cycle %0d, expected %h at cycle %0d",
                             instr, cyc, e.word, e.cyc);
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] w);
        exp_t e;
        e.word = w;
        e.cyc  = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic frame_edge(input logic [31:0] w);
        @(negedge clk);
        frame = 1'b1;
        expect_word(w);
        repeat (4) @(negedge clk);
        frame = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input int n);
        @(negedge clk);
        key = 1'b1;
        repeat (n) @(negedge clk);
        key = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks = checks + 1;
        if (instr !== 32'h0) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected 00000000", name, instr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        key    = 1'b0;
        frame  = 1'b0;

        // Held in reset with inputs toggling: output stays NOP.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key   = i[0];
            frame = i[1];
            #1 check_zero("reset_hold");
        end
        @(negedge clk);
        key   = 1'b0;
        frame = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Bare frame edge.
        frame_edge(32'hA8000001);

        // Held press then two frames.
        press(10);
        frame_edge(32'hA8000003);
        frame_edge(32'hA8000001);

        // Glitch shorter than debounce window.
        press(3);
        frame_edge(32'hA8000001);

        // Two presses collapse into one.
        press(10);
        press(10);
        frame_edge(32'hA8000003);
        frame_edge(32'hA8000001);

        // Press lands on the tick cycle: key raised at cycle c gives
        // press after edge c+6; frame raised at c+4 gives tick there too.
        @(negedge clk);
        key = 1'b1;
        repeat (4) @(negedge clk);
        frame = 1'b1;
        expect_word(32'hA8000003);
        repeat (6) @(negedge clk);
        frame = 1'b0;
        key   = 1'b0;
        repeat (12) @(negedge clk);
        frame_edge(32'hA8000001);

        // Reset with a press pending clears everything.
        press(10);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) begin
            @(negedge clk);
            #1 check_zero("reset_again");
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        frame_edge(32'hA8000001);

        repeat (10) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL missing_instr got %0d outstanding expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
